uart_letter_rx: RTL

Serial front end for the letter-pattern detectors. It receives 8N1 asynchronous serial characters on a single line and optionally folds lowercase ASCII to uppercase. Each character is presented on an 8-bit letter bus with a one-cycle valid strobe. In the top level, letter_valid is the clock enable of the downstream pattern detector, so the detector advances exactly once per received character.

---
 rtl/uart_letter_rx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_letter_rx.sv
// 8N1 serial receiver feeding the letter-pattern detectors. It optionally folds
// lowercase ASCII to uppercase and emits one letter_valid strobe per good character.
module uart_letter_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit UPPERCASE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    letter_n;
  logic          valid_n, ferr_n;
  logic          rx_meta, rx_s;

  function automatic logic [7:0] fold(input logic [7:0] b);
    if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
    return b;
  endfunction

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
      // two stages form a real 2-cycle pipeline instead of collapsing into one.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      letter       <= '0;
      letter_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      letter       <= letter_n;
      letter_valid <= valid_n;
      frame_err    <= ferr_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    letter_n  = letter;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // Sampling lands mid-bit because the count was aligned at mid start bit.
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            letter_n = fold(shreg);
            valid_n  = 1'b1;
            state_n  = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
